// File: rtl/rand_spawn_gen.sv
// Random spawn-record generator: an XNOR LFSR proposes (column, character, speed, line) candidates and rejection-samples them.
// Latency: 2 cycles minimum from en sampled high to out_valid; 1 record per 2 cycles at best, plus one cycle per rejected candidate.
// Backpressure: a record is held bit-stable in HOLD until out_ready; en low discards it. Optional macro RAND_SPAWN_NODUP_EN adds duplicate suppression.
module rand_spawn_gen #(
  parameter int          LFSR_W  = 32,
  parameter logic [63:0] TAPS    = 64'h0000_0000_8020_0003,
  parameter int          COLS    = 52,
  parameter int          LN_W    = 1,
  parameter logic [7:0]  VMIN    = 8'd16,
  parameter int          REJ_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [LFSR_W-1:0] seed,
  input  logic [1:0]        mode,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [7:0]        velocity,
  output logic [5:0]        position,
  output logic [7:0]        asciicode,
  output logic [LN_W-1:0]   linenum,
  output logic [15:0]       spawn_cnt
);

  localparam int                RTY_W    = (REJ_MAX < 1) ? 1 : $clog2(REJ_MAX + 1);
  localparam logic [LFSR_W-1:0] TAP_MASK = TAPS[LFSR_W-1:0];
  localparam logic [RTY_W-1:0]  RTY_LIM  = RTY_W'(REJ_MAX);
  localparam logic [6:0]        COLS_LIM = 7'(COLS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state;
  logic [LFSR_W-1:0] lfsr;
  logic [RTY_W-1:0]  retry;

  // Load value and next state of the generator; all-ones is the XNOR lockup state
  logic [LFSR_W-1:0] load_val;
  logic [LFSR_W-1:0] lfsr_next;
  assign load_val  = (seed == '1) ? {seed[LFSR_W-1:1], 1'b0} : seed;
  assign lfsr_next = {lfsr[LFSR_W-2:0], ~^(lfsr & TAP_MASK)};

  // Candidate fields sliced straight out of the current LFSR state
  logic [5:0]      pos_raw;
  logic [5:0]      chr;
  logic            upper;
  logic [7:0]      vel_raw;
  logic [LN_W-1:0] line;
  assign pos_raw = lfsr[5:0];
  assign chr     = lfsr[13:8];
  assign upper   = lfsr[14];
  assign vel_raw = lfsr[23:16];
  assign line    = lfsr[24 +: LN_W];

  logic [7:0] cand_chr;
  logic       chr_ok;
  logic       pos_ok;
  logic       cand_dup;
  logic       accept;
  logic       force_acc;
  logic [7:0] vel_cand;

  // Map the 6-bit character draw onto the selected character set
  always_comb begin
    cand_chr = 8'h61 + {3'b000, chr[4:0]};
    chr_ok   = (chr[4:0] < 5'd26);
    case (mode)
      2'b01: begin
        if (upper) cand_chr = 8'h41 + {3'b000, chr[4:0]};
      end
      2'b10: begin
        chr_ok = (chr < 6'd36);
        if (chr < 6'd26) cand_chr = 8'h61 + {2'b00, chr};
        else             cand_chr = 8'h30 + {2'b00, chr} - 8'd26;
      end
      default: ;
    endcase
  end

`ifdef RAND_SPAWN_NODUP_EN
  // Last character the consumer actually took; only meaningful once something was taken
  logic [7:0] prev_chr;
  assign cand_dup = (spawn_cnt != 16'd0) && (cand_chr == prev_chr);
`else
  assign cand_dup = 1'b0;
`endif

  assign pos_ok    = ({1'b0, pos_raw} < COLS_LIM);
  assign accept    = pos_ok && chr_ok && !cand_dup;
  assign force_acc = (retry == RTY_LIM);
  assign vel_cand  = (vel_raw < VMIN) ? VMIN : vel_raw;

  // Control FSM with registered record outputs; rst outranks en, en low outranks everything else
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lfsr      <= load_val;
      retry     <= '0;
      out_valid <= 1'b0;
      velocity  <= '0;
      position  <= '0;
      asciicode <= '0;
      linenum   <= '0;
      spawn_cnt <= '0;
`ifdef RAND_SPAWN_NODUP_EN
      prev_chr  <= '0;
`endif
    end else if (!en) begin
      state     <= IDLE;
      lfsr      <= load_val;
      retry     <= '0;
      out_valid <= 1'b0;
      velocity  <= '0;
      position  <= '0;
      asciicode <= '0;
      linenum   <= '0;
    end else begin
      case (state)
        IDLE: begin
          lfsr      <= load_val;
          retry     <= '0;
          out_valid <= 1'b0;
          velocity  <= '0;
          position  <= '0;
          asciicode <= '0;
          linenum   <= '0;
          state     <= GEN;
        end
        GEN: begin
          if (force_acc) begin
            // Too many rejections in a row: emit a safe record from the current draw
            position  <= 6'd1;
            asciicode <= 8'h61;
            velocity  <= vel_cand;
            linenum   <= line;
            out_valid <= 1'b1;
            retry     <= '0;
            state     <= HOLD;
          end else if (accept) begin
            position  <= pos_raw + 6'd1;
            asciicode <= cand_chr;
            velocity  <= vel_cand;
            linenum   <= line;
            out_valid <= 1'b1;
            retry     <= '0;
            state     <= HOLD;
          end else begin
            lfsr  <= lfsr_next;
            retry <= retry + RTY_W'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            lfsr      <= lfsr_next;
            state     <= GEN;
            if (spawn_cnt != 16'hFFFF) spawn_cnt <= spawn_cnt + 16'd1;
`ifdef RAND_SPAWN_NODUP_EN
            prev_chr  <= asciicode;
`endif
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rand_spawn_gen.sv
// Self-checking bench for rand_spawn_gen: vector table of runs plus hand-written hold/drop/reset sequences.
// Expected records come from a behavioural LFSR model and are queued, then popped at each observed handshake.
// A second instance with COLS=1 is checked for column and character-set properties.
module tb_rand_spawn_gen;

  logic        clk = 1'b0;
  logic        rst, en, out_ready;
  logic [31:0] seed;
  logic [1:0]  mode;

  logic        out_valid;
  logic [7:0]  velocity, asciicode;
  logic [5:0]  position;
  logic [0:0]  linenum;
  logic [15:0] spawn_cnt;

  logic        out_valid_c1;
  logic [7:0]  velocity_c1, asciicode_c1;
  logic [5:0]  position_c1;
  logic [0:0]  linenum_c1;
  logic [15:0] spawn_cnt_c1;

  always #5 clk = ~clk;

  rand_spawn_gen dut (
    .clk(clk), .rst(rst), .en(en), .seed(seed), .mode(mode), .out_ready(out_ready),
    .out_valid(out_valid), .velocity(velocity), .position(position),
    .asciicode(asciicode), .linenum(linenum), .spawn_cnt(spawn_cnt)
  );

  rand_spawn_gen #(.COLS(1)) dut_c1 (
    .clk(clk), .rst(rst), .en(en), .seed(seed), .mode(mode), .out_ready(1'b1),
    .out_valid(out_valid_c1), .velocity(velocity_c1), .position(position_c1),
    .asciicode(asciicode_c1), .linenum(linenum_c1), .spawn_cnt(spawn_cnt_c1)
  );

  typedef struct {
    logic [7:0] vel;
    logic [5:0] pos;
    logic [7:0] chr;
    logic       ln;
    int         retries;
  } rec_t;

  typedef struct {
    logic [31:0] seed;
    logic [1:0]  mode;
    int          nrec;
    bit          stall;
    logic [7:0]  lo;
    logic [7:0]  hi;
  } vec_t;

  rec_t        q[$];
  vec_t        vecs[5];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          hs_count = 0;
  logic [15:0] exp_cnt = 16'd0;
  logic [31:0] m_lfsr;
  logic [7:0]  m_prev = 8'd0;
  int          m_cnt = 0;
  logic [7:0]  last_hs = 8'd0;
  bit          last_hs_v = 1'b0;
  logic [7:0]  cur_lo = 8'd97, cur_hi = 8'd122;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic [31:0] m_step(input logic [31:0] s);
    return {s[30:0], ~^(s & 32'h8020_0003)};
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] sd);
    return (sd == 32'hFFFF_FFFF) ? 32'hFFFF_FFFE : sd;
  endfunction

  // Model of one record: draw, reject, retry up to 15 times, then fall back; handshake steps once more
  task automatic gen_one(input logic [1:0] md, output rec_t r);
    logic [5:0] pos, c;
    logic [4:0] c5;
    logic [7:0] ch;
    bit         ok;
    int         retry;
    retry = 0;
    forever begin
      pos = m_lfsr[5:0];
      c   = m_lfsr[13:8];
      c5  = c[4:0];
      r.vel     = (m_lfsr[23:16] < 8'd16) ? 8'd16 : m_lfsr[23:16];
      r.ln      = m_lfsr[24];
      r.retries = retry;
      if (retry == 15) begin
        r.pos = 6'd1;
        r.chr = 8'h61;
        break;
      end
      case (md)
        2'b10: begin
          ok = (c < 6'd36);
          ch = (c < 6'd26) ? 8'd97 + 8'(c) : 8'd48 + 8'(c) - 8'd26;
        end
        2'b01: begin
          ok = (c5 < 5'd26);
          ch = (m_lfsr[14] ? 8'd65 : 8'd97) + 8'(c5);
        end
        default: begin
          ok = (c5 < 5'd26);
          ch = 8'd97 + 8'(c5);
        end
      endcase
      ok = ok && (pos < 6'd52);
`ifdef RAND_SPAWN_NODUP_EN
      if (m_cnt > 0 && ch == m_prev) ok = 1'b0;
`endif
      if (ok) begin
        r.pos = pos + 6'd1;
        r.chr = ch;
        break;
      end
      m_lfsr = m_step(m_lfsr);
      retry++;
    end
    m_lfsr = m_step(m_lfsr);
    m_prev = r.chr;
    m_cnt++;
  endtask

  task automatic push_run(input logic [31:0] sd, input logic [1:0] md, input int n);
    rec_t r;
    m_lfsr = m_load(sd);
    for (int i = 0; i < n; i++) begin
      gen_one(md, r);
      q.push_back(r);
    end
  endtask

  task automatic do_reset(input logic [31:0] sd);
    @(posedge clk); #1;
    rst = 1'b1; en = 1'b0; out_ready = 1'b0; seed = sd;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = 16'd0; m_cnt = 0; m_prev = 8'd0; last_hs_v = 1'b0;
    q.delete();
  endtask

  task automatic run_until(input int target, input int budget, input bit stall);
    for (int c = 0; c < budget && hs_count < target; c++) begin
      @(posedge clk); #1;
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    out_ready = 1'b0;
    check("run_complete", 64'(hs_count >= target), 64'd1);
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (!out_valid && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    check(name, 64'(out_valid), 64'd1);
  endtask

  // Scoreboard: every accepted handshake is compared against the next queued model record
  always @(negedge clk) begin
    if (!rst && en && out_valid && out_ready) begin
      rec_t e;
      if (q.size() == 0) begin
        check("unexpected_handshake", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        n_cmp++;
        if ({velocity, position, asciicode, linenum[0]} !== {e.vel, e.pos, e.chr, e.ln}) begin
          n_bad++;
          $display("FAIL record[%0d]: got vel=%0d pos=%0d chr=%0d ln=%0d, want vel=%0d pos=%0d chr=%0d ln=%0d",
                   hs_count, velocity, position, asciicode, linenum, e.vel, e.pos, e.chr, e.ln);
        end
      end
      check("spawn_cnt_at_hs", 64'(spawn_cnt), 64'(exp_cnt));
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      check("field_ranges",
            64'(asciicode >= cur_lo && asciicode <= cur_hi && position >= 6'd1 &&
                position <= 6'd52 && velocity >= 8'd16), 64'd1);
`ifdef RAND_SPAWN_NODUP_EN
      check("no_consecutive_dup",
            64'(last_hs_v && asciicode == last_hs && asciicode != 8'h61), 64'd0);
`endif
      last_hs   = asciicode;
      last_hs_v = 1'b1;
      hs_count++;
    end
  end

  // Narrow-field instance: always column 1; digits or lowercase only in mode 10
  always @(negedge clk) begin
    if (!rst && en && out_valid_c1) begin
      check("cols1_record",
            64'(position_c1 == 6'd1 && velocity_c1 >= 8'd16 &&
                (mode != 2'b10 || (asciicode_c1 >= 8'd48 && asciicode_c1 <= 8'd57) ||
                 (asciicode_c1 >= 8'd97 && asciicode_c1 <= 8'd122))), 64'd1);
    end
  end

  initial begin
    logic [63:0] snap;
    logic [15:0] cnt0;
    logic [7:0]  sv_prev;
    int          sv_cnt, lat, k, tgt;
    bit          changed;

    rst = 1'b1; en = 1'b0; out_ready = 1'b0; seed = 32'hFFFF_FFFF; mode = 2'b00;

    vecs[0] = '{32'h0000_0001, 2'b00, 10000, 1'b0, 8'd97, 8'd122};
    vecs[1] = '{32'hDEAD_BEEF, 2'b01, 300,   1'b1, 8'd65, 8'd122};
    vecs[2] = '{32'h1234_5678, 2'b10, 300,   1'b1, 8'd48, 8'd122};
    vecs[3] = '{32'hFFFF_FFFF, 2'b11, 300,   1'b0, 8'd97, 8'd122};
    vecs[4] = '{32'h0000_0000, 2'b00, 200,   1'b1, 8'd97, 8'd122};

    // Reset with the lockup seed
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset_lfsr", 64'(dut.lfsr), 64'hFFFF_FFFE);
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_fields", 64'({velocity, position, asciicode, linenum}), 64'd0);
    check("reset_cnt", 64'(spawn_cnt), 64'd0);
    rst = 1'b0;

    // Latency, hold stability under backpressure, and the release handshake
    do_reset(32'h0BAD_F00D);
    mode = 2'b00; cur_lo = 8'd97; cur_hi = 8'd122;
    push_run(32'h0BAD_F00D, 2'b00, 1);
    lat = q[0].retries + 2;
    en = 1'b1;
    k = 0;
    while (!out_valid && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    check("first_latency", 64'(k), 64'(lat));
    snap = 64'({velocity, position, asciicode, linenum, spawn_cnt});
    cnt0 = spawn_cnt;
    changed = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (64'({velocity, position, asciicode, linenum, spawn_cnt}) != snap || !out_valid) changed = 1'b1;
    end
    check("hold_stable", 64'(changed), 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_valid_drop", 64'(out_valid), 64'd0);
    check("release_cnt_inc", 64'(spawn_cnt), 64'(cnt0 + 16'd1));
    check("release_queue", 64'(q.size()), 64'd0);

    // en dropped in HOLD discards the record; same seed replays the same sequence
    do_reset(32'hC0FF_EE11);
    sv_prev = m_prev; sv_cnt = m_cnt;
    push_run(32'hC0FF_EE11, 2'b00, 1);
    en = 1'b1;
    wait_valid("drop_wait_valid");
    cnt0 = spawn_cnt;
    @(posedge clk); #1;
    en = 1'b0;
    @(posedge clk); #1;
    check("drop_valid", 64'(out_valid), 64'd0);
    check("drop_fields", 64'({velocity, position, asciicode, linenum}), 64'd0);
    check("drop_cnt", 64'(spawn_cnt), 64'(cnt0));
    q.delete();
    m_prev = sv_prev; m_cnt = sv_cnt;
    push_run(32'hC0FF_EE11, 2'b00, 6);
    en = 1'b1;
    tgt = hs_count + 6;
    run_until(tgt, 400, 1'b0);

    // Reset in HOLD drops the record without counting it
    wait_valid("rst_wait_valid");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_hold_valid", 64'(out_valid), 64'd0);
    check("rst_hold_cnt", 64'(spawn_cnt), 64'd0);
    rst = 1'b0; en = 1'b0;

    // Table-driven runs
    for (int i = 0; i < 5; i++) begin
      do_reset(vecs[i].seed);
      mode = vecs[i].mode;
      cur_lo = vecs[i].lo;
      cur_hi = vecs[i].hi;
      push_run(vecs[i].seed, vecs[i].mode, vecs[i].nrec);
      en = 1'b1;
      tgt = hs_count + vecs[i].nrec;
      run_until(tgt, vecs[i].nrec * 40 + 100, vecs[i].stall);
      en = 1'b0;
      check("vector_queue_drained", 64'(q.size()), 64'd0);
    end

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
